// File: rtl/tinyqv_nibble_mem_responder_pkg.sv
// Shared encodings for the TinyQV nibble-serial memory responder: access sizes,
// FSM states and the load-data alignment helper.
package tinyqv_nibble_mem_responder_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } resp_state_e;

  // Right-align the addressed lane(s) of a RAM word; unused upper bits read as zero.
  function automatic logic [31:0] alignLoad(input logic [31:0] word,
                                            input logic [1:0]  byteAddr,
                                            input logic [1:0]  size);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word;
    result  = word;
    case (size)
      MEM_BYTE: begin
        shifted = word >> {byteAddr, 3'b000};
        result  = {24'h000000, shifted[7:0]};
      end
      MEM_HALF: begin
        shifted = word >> {byteAddr[1], 4'b0000};
        result  = {16'h0000, shifted[15:0]};
      end
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tinyqv_nibble_mem_responder_ram.sv
// Backing word store for the responder: synchronous byte-enabled write,
// combinational read, so it can be swapped for a hard macro wrapper.
module tinyqv_resp_ram #(
  parameter int NUM_WORDS = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tinyqv_nibble_mem_responder.sv
// Nibble-serial load/store responder for the TinyQV core backed by on-chip RAM.
// Optional macro TINYQV_RESP_ERR_EN adds the access_err reporting output.
module tinyqv_nibble_mem_responder
  import tinyqv_nibble_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS      = 64,
  parameter int WORD_ADDR_BITS = 6,
  parameter int LOAD_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  counter,
  input  logic [27:0] addr_in,
  input  logic        address_ready,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [3:0]  store_data,
  output logic [3:0]  load_data,
  output logic        load_data_ready,
  output logic        busy
`ifdef TINYQV_RESP_ERR_EN
  ,
  output logic        access_err
`endif
);

  localparam int         BA      = WORD_ADDR_BITS + 2;
  localparam logic [2:0] LatInit = 3'(LOAD_LATENCY);

  resp_state_e         state_q, state_d;
  logic [2:0]          passCnt_q, passCnt_d;
  logic [BA-1:0]       ldAddr_q, ldAddr_d;
  logic [1:0]          ldOp_q, ldOp_d;
  logic                ldOor_q, ldOor_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         storeBuf_q;

  logic [31:0]         storeWord;
  logic                inRange;
  logic                ramWe;
  logic [3:0]          ramBe;
  logic [31:0]         ramWdata;
  logic [31:0]         ramRdata;
  logic                unusedBits;

  assign unusedBits = ^{mem_op[2], storeBuf_q[3:0]};

  // Store nibbles enter at the top so nibble k sits at [4k+3:4k] after a full pass.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      storeBuf_q <= '0;
    end else begin
      storeBuf_q <= {store_data, storeBuf_q[31:4]};
    end
  end

  assign storeWord = {store_data, storeBuf_q[31:4]};
  assign inRange   = (addr_in[27:BA] == '0);

  always_comb begin
    ramWdata = storeWord;
    ramBe    = 4'b1111;
    case (mem_op[1:0])
      MEM_BYTE: begin
        ramWdata = {4{storeWord[7:0]}};
        ramBe    = 4'b0001 << addr_in[1:0];
      end
      MEM_HALF: begin
        ramWdata = {2{storeWord[15:0]}};
        ramBe    = addr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ramWe = (state_q == IDLE) && address_ready && is_store && inRange;

  tinyqv_resp_ram #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_BITS (WORD_ADDR_BITS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ramWe),
    .be_i    (ramBe),
    .waddr_i (addr_in[BA-1:2]),
    .wdata_i (ramWdata),
    .raddr_i (ldAddr_q[BA-1:2]),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      passCnt_q <= '0;
      ldAddr_q  <= '0;
      ldOp_q    <= MEM_BYTE;
      ldOor_q   <= 1'b0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      passCnt_q <= passCnt_d;
      ldAddr_q  <= ldAddr_d;
      ldOp_q    <= ldOp_d;
      ldOor_q   <= ldOor_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    passCnt_d = passCnt_q;
    ldAddr_d  = ldAddr_q;
    ldOp_d    = ldOp_q;
    ldOor_d   = ldOor_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        if (address_ready && !is_store) begin
          ldAddr_d  = addr_in[BA-1:0];
          ldOp_d    = mem_op[1:0];
          ldOor_d   = !inRange;
          passCnt_d = LatInit;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (counter == 3'd7) begin
          passCnt_d = passCnt_q - 3'd1;
          // Final idle pass: fetch now so the data pass starts on the next counter 0.
          if (passCnt_q == 3'd1) begin
            shift_d = ldOor_q ? 32'h0 : alignLoad(ramRdata, ldAddr_q[1:0], ldOp_q);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        shift_d = {4'h0, shift_q[31:4]};
        if (counter == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_data_ready = (state_q == DATA);
  assign load_data       = (state_q == DATA) ? shift_q[3:0] : 4'h0;
  assign busy            = (state_q != IDLE);

`ifdef TINYQV_RESP_ERR_EN
  logic misaligned;
  logic err_q, err_d;

  assign misaligned = ((mem_op[1:0] == MEM_HALF) && addr_in[0]) ||
                      ((mem_op[1:0] == MEM_WORD) && (addr_in[1:0] != 2'b00));
  assign err_d      = address_ready && ((state_q != IDLE) || !inRange || misaligned);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign access_err = err_q;
`endif

endmodule
